// File: rtl/vga_sync_decoder.sv
// VGA capture-side decoder: measures sync timing, recovers pixel coordinates, tracks lock.
// Define VGA_SYNC_DECODER_CHECKSUM_EN to build the per-frame colour checksum on o_frame_sum.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 304,
  parameter int H_BACK      = 22,
  parameter int V_ACTIVE    = 480,
  parameter int V_BACK      = 35,
  parameter int LOCK_FRAMES = 2,
  parameter int TOL         = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [3:0]  i_red,
  input  logic [3:0]  i_green,
  input  logic [3:0]  i_blue,
  output logic [9:0]  o_pixel_x,
  output logic [9:0]  o_pixel_y,
  output logic        o_pixel_valid,
  output logic [11:0] o_color,
  output logic [9:0]  o_line_clocks,
  output logic [9:0]  o_hsync_width,
  output logic [9:0]  o_frame_lines,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic        o_error,
  output logic [15:0] o_frame_sum
);

  localparam logic [9:0] CMAX = 10'd1023;
  localparam logic [9:0] HB   = 10'(H_BACK);
  localparam logic [9:0] HE   = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0] VB   = 10'(V_BACK);
  localparam logic [9:0] VE   = 10'(V_BACK + V_ACTIVE);
  localparam logic [9:0] TL   = 10'(TOL);
  localparam logic [2:0] LF   = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_t;

  function automatic logic [9:0] inc_sat(input logic [9:0] v);
    return (v == CMAX) ? v : v + 10'd1;
  endfunction

  function automatic logic in_tol(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] d;
    d = (a >= b) ? a - b : b - a;
    return d <= TL;
  endfunction

  logic        s1_h_q, s1_v_q, s2_h_q, s2_v_q;
  logic [11:0] s1_col_q, s2_col_q;
  logic [9:0]  hcnt_q, hcnt_d, hpos_q, hpos_d;
  logic [9:0]  lcnt_q, lcnt_d, vpos_q, vpos_d;
  logic [9:0]  line_clk_q, line_clk_d, hs_w_q, hs_w_d;
  logic [9:0]  fr_lines_q, fr_lines_d;
  logic        fs_q, err_q, err_d;
  state_t      state_q, state_d;
  logic [2:0]  stable_q, stable_d;
  logic        ref_ok_q, ref_ok_d;
  logic [9:0]  ref_clk_q, ref_clk_d, ref_lines_q, ref_lines_d;
  logic        pix_v_q, pix_v_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] color_q, color_d;
  logic [9:0]  line_q, width_q, lines_q;
  logic        locked_q, locked_d, fstart_q, error_q;

  logic       hfall, hrise, vfall, vrise, act, lost;
  logic       frame_ok, bad_line, bad_frame;
  logic [9:0] meas_clk, cur_clk;

  assign hfall = s2_h_q & ~s1_h_q;
  assign hrise = ~s2_h_q & s1_h_q;
  assign vfall = s2_v_q & ~s1_v_q;
  assign vrise = ~s2_v_q & s1_v_q;

  assign meas_clk = inc_sat(hcnt_q);
  assign cur_clk  = hfall ? meas_clk : line_clk_q;

  // fires once, on the clock hcnt reaches its ceiling
  assign lost = (hcnt_q == CMAX - 10'd1) && !hfall;

  assign frame_ok  = (lcnt_q == ref_lines_q) && in_tol(cur_clk, ref_clk_q);
  assign bad_line  = hfall && !in_tol(meas_clk, ref_clk_q);
  assign bad_frame = vfall && (lcnt_q != ref_lines_q);

  always_comb begin
    hcnt_d     = hfall ? 10'd0 : inc_sat(hcnt_q);
    line_clk_d = hfall ? meas_clk : line_clk_q;
    hs_w_d     = hrise ? meas_clk : hs_w_q;
    hpos_d     = hrise ? 10'd0 : inc_sat(hpos_q);
    fr_lines_d = vfall ? lcnt_q : fr_lines_q;
    lcnt_d     = lcnt_q;
    if (vfall) begin
      lcnt_d = hrise ? 10'd1 : 10'd0;
    end else if (hrise) begin
      lcnt_d = inc_sat(lcnt_q);
    end
    vpos_d = vpos_q;
    if (vrise) begin
      vpos_d = 10'd0;
    end else if (hrise) begin
      vpos_d = inc_sat(vpos_q);
    end
  end

  always_comb begin
    act = (hpos_q >= HB) && (hpos_q < HE) &&
          (vpos_q >= VB) && (vpos_q < VE);
    pix_v_d = act;
    pix_x_d = act ? hpos_q - HB : 10'd0;
    pix_y_d = act ? vpos_q - VB : 10'd0;
    color_d = act ? s2_col_q : 12'd0;
  end

  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    ref_ok_d    = ref_ok_q;
    ref_clk_d   = ref_clk_q;
    ref_lines_d = ref_lines_q;
    err_d       = 1'b0;
    if (lost) begin
      state_d  = SEARCH;
      stable_d = 3'd0;
      ref_ok_d = 1'b0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (vfall) begin
            state_d  = TRACK;
            stable_d = 3'd0;
            ref_ok_d = 1'b0;
          end
        end
        TRACK: begin
          if (vfall) begin
            if (!ref_ok_q || !frame_ok) begin
              ref_ok_d    = 1'b1;
              ref_clk_d   = cur_clk;
              ref_lines_d = lcnt_q;
              stable_d    = 3'd0;
            end else begin
              stable_d = stable_q + 3'd1;
              if (stable_d == LF) state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (bad_line || bad_frame) begin
            err_d       = 1'b1;
            state_d     = TRACK;
            stable_d    = 3'd0;
            ref_clk_d   = cur_clk;
            ref_lines_d = lcnt_q;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_h_q      <= 1'b1;
      s1_v_q      <= 1'b1;
      s2_h_q      <= 1'b1;
      s2_v_q      <= 1'b1;
      s1_col_q    <= '0;
      s2_col_q    <= '0;
      hcnt_q      <= '0;
      hpos_q      <= '0;
      lcnt_q      <= '0;
      vpos_q      <= '0;
      line_clk_q  <= '0;
      hs_w_q      <= '0;
      fr_lines_q  <= '0;
      fs_q        <= 1'b0;
      err_q       <= 1'b0;
      state_q     <= SEARCH;
      stable_q    <= '0;
      ref_ok_q    <= 1'b0;
      ref_clk_q   <= '0;
      ref_lines_q <= '0;
      pix_v_q     <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      color_q     <= '0;
      line_q      <= '0;
      width_q     <= '0;
      lines_q     <= '0;
      locked_q    <= 1'b0;
      fstart_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      s1_h_q      <= i_hsync;
      s1_v_q      <= i_vsync;
      s2_h_q      <= s1_h_q;
      s2_v_q      <= s1_v_q;
      s1_col_q    <= {i_red, i_green, i_blue};
      s2_col_q    <= s1_col_q;
      hcnt_q      <= hcnt_d;
      hpos_q      <= hpos_d;
      lcnt_q      <= lcnt_d;
      vpos_q      <= vpos_d;
      line_clk_q  <= line_clk_d;
      hs_w_q      <= hs_w_d;
      fr_lines_q  <= fr_lines_d;
      fs_q        <= vfall;
      err_q       <= err_d;
      state_q     <= state_d;
      stable_q    <= stable_d;
      ref_ok_q    <= ref_ok_d;
      ref_clk_q   <= ref_clk_d;
      ref_lines_q <= ref_lines_d;
      pix_v_q     <= pix_v_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      color_q     <= color_d;
      line_q      <= line_clk_q;
      width_q     <= hs_w_q;
      lines_q     <= fr_lines_q;
      locked_q    <= locked_d;
      fstart_q    <= fs_q;
      error_q     <= err_q;
    end
  end

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d, fsum_q, fsum_d;

  always_comb begin
    sum_d  = (fs_q ? 16'd0 : sum_q) + (act ? {4'h0, s2_col_q} : 16'd0);
    fsum_d = fs_q ? sum_q : fsum_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q  <= '0;
      fsum_q <= '0;
    end else begin
      sum_q  <= sum_d;
      fsum_q <= fsum_d;
    end
  end

  assign o_frame_sum = fsum_q;
`else
  assign o_frame_sum = 16'd0;
`endif

  assign o_pixel_valid = pix_v_q;
  assign o_pixel_x     = pix_x_q;
  assign o_pixel_y     = pix_y_q;
  assign o_color       = color_q;
  assign o_line_clocks = line_q;
  assign o_hsync_width = width_q;
  assign o_frame_lines = lines_q;
  assign o_locked      = locked_q;
  assign o_frame_start = fstart_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken raster:
// 20-clock lines (4 low), 8-line frames (2 low), 8x4 active window.
module tb_vga_sync_decoder;

  localparam int P  = 20;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HA = 8;
  localparam int NL = 8;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VA = 4;

  logic        clk;
  logic        rst_n;
  logic        i_hsync, i_vsync;
  logic [3:0]  i_red, i_green, i_blue;
  logic [9:0]  o_pixel_x, o_pixel_y;
  logic        o_pixel_valid;
  logic [11:0] o_color;
  logic [9:0]  o_line_clocks, o_hsync_width, o_frame_lines;
  logic        o_locked, o_frame_start, o_error;
  logic [15:0] o_frame_sum;

  int n_checks = 0;
  int n_errors = 0;
  int n_fs, n_err, n_val, n_bad;

  logic        pc   [3];
  logic [32:0] pexp [3];

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB),
    .LOCK_FRAMES(2), .TOL(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_pixel_x(o_pixel_x), .o_pixel_y(o_pixel_y),
    .o_pixel_valid(o_pixel_valid), .o_color(o_color),
    .o_line_clocks(o_line_clocks), .o_hsync_width(o_hsync_width),
    .o_frame_lines(o_frame_lines), .o_locked(o_locked),
    .o_frame_start(o_frame_start), .o_error(o_error),
    .o_frame_sum(o_frame_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_pipe();
    for (int k = 0; k < 3; k++) begin
      pc[k]   = 1'b0;
      pexp[k] = '0;
    end
  endtask

  // one clock: compare the sample driven three negedges ago, then drive
  task automatic step(input logic h, input logic v,
                      input logic [11:0] col, input logic c,
                      input logic [32:0] e);
    @(negedge clk);
    n_fs  += int'(o_frame_start);
    n_err += int'(o_error);
    n_val += int'(o_pixel_valid);
    if (pc[2] && ({o_pixel_valid, o_pixel_x, o_pixel_y, o_color}
                  !== pexp[2]))
      n_bad++;
    pc[2] = pc[1]; pexp[2] = pexp[1];
    pc[1] = pc[0]; pexp[1] = pexp[0];
    pc[0] = c;     pexp[0] = e;
    i_hsync = h;
    i_vsync = v;
    {i_red, i_green, i_blue} = col;
  endtask

  task automatic gen_line(input int l, input int i0, input int i1,
                          input logic vs, input logic care,
                          input logic cmode);
    for (int i = i0; i < i1; i++) begin
      int hp, vp;
      logic act;
      logic [11:0] col;
      hp  = i - HS;
      vp  = l - VS + 1;
      act = (i >= HS) && (hp >= HB) && (hp < HB + HA) &&
            (l >= VS) && (vp >= VB) && (vp < VB + VA);
      col = cmode ? 12'h00F : (act ? 12'(hp - HB) : 12'hA5A);
      step(i >= HS, vs, col, care,
           act ? {1'b1, 10'(hp - HB), 10'(vp - VB), col} : 33'd0);
    end
  endtask

  task automatic gen_frame(input int l0, input int l1, input int sl,
                           input int ext, input logic care,
                           input logic cmode);
    n_fs = 0; n_err = 0; n_val = 0; n_bad = 0;
    for (int l = l0; l < l1; l++)
      gen_line(l, 0, P + ((l == sl) ? ext : 0), l >= VS, care, cmode);
    if (care) begin
      check("pix_mismatch", n_bad, 0);
      check("pix_count", n_val, HA * VA);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_hsync = 1'b1; i_vsync = 1'b1;
    {i_red, i_green, i_blue} = 12'd0;
    n_fs = 0; n_err = 0; n_val = 0; n_bad = 0;
    clear_pipe();
    repeat (4) step(1'b1, 1'b1, 12'd0, 1'b0, 33'd0);
    #1;
    check("rst_pix", {o_pixel_valid, o_pixel_x, o_pixel_y, o_color}, 0);
    check("rst_meas", {o_line_clocks, o_hsync_width, o_frame_lines}, 0);
    check("rst_stat", {o_locked, o_frame_start, o_error, o_frame_sum}, 0);
    step(1'b1, 1'b1, 12'd0, 1'b0, 33'd0);
    rst_n = 1'b1;

    // acquisition from reset
    for (int f = 1; f <= 4; f++) begin
      gen_frame(0, NL, -1, 0, f > 1, 1'b0);
      if (f == 3) check("lock_f3", o_locked, 0);
    end
    check("lock_f4", o_locked, 1);
    check("line_clocks", o_line_clocks, P);
    check("hsync_width", o_hsync_width, HS);
    check("frame_lines", o_frame_lines, NL);
    check("frame_start_cnt", n_fs, 1);

    // 22-clock line while locked
    gen_frame(0, NL, 4, 2, 1'b1, 1'b0);
    check("glitch_err", n_err, 1);
    check("glitch_unlock", o_locked, 0);
    gen_frame(0, NL, -1, 0, 1'b1, 1'b0);
    check("relock_a", o_locked, 0);
    gen_frame(0, NL, -1, 0, 1'b1, 1'b0);
    check("relock_b", o_locked, 0);
    gen_frame(0, NL, -1, 0, 1'b1, 1'b0);
    check("relock_c", o_locked, 1);
    check("relock_err", n_err, 0);

    // 21-clock line is within tolerance
    gen_frame(0, NL, 4, 1, 1'b1, 1'b0);
    check("tol_err", n_err, 0);
    check("tol_lock", o_locked, 1);

    // hsync loss
    n_err = 0;
    repeat (1100) step(1'b1, 1'b1, 12'hA5A, 1'b1, 33'd0);
    check("loss_unlock", o_locked, 0);
    check("loss_err", n_err, 0);
    gen_line(0, 0, P, 1'b0, 1'b1, 1'b0);
    check("loss_sat", o_line_clocks, 1023);
    gen_frame(1, NL, -1, 0, 1'b1, 1'b0);
    check("loss_lock1", o_locked, 0);
    for (int f = 2; f <= 4; f++) gen_frame(0, NL, -1, 0, 1'b1, 1'b0);
    check("loss_relock", o_locked, 1);

    // constant-colour frame for the checksum
    gen_frame(0, NL, -1, 0, 1'b1, 1'b1);
    gen_line(0, 0, P, 1'b0, 1'b1, 1'b0);
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    check("frame_sum", o_frame_sum, (15 * HA * VA) % 65536);
`else
    check("frame_sum", o_frame_sum, 0);
`endif
    gen_frame(1, NL, -1, 0, 1'b1, 1'b0);

    // asynchronous reset in the middle of an active line
    gen_frame(0, 4, -1, 0, 1'b0, 1'b0);
    gen_line(4, 0, HS + HB + 4, 1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", o_pixel_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pix", {o_pixel_valid, o_pixel_x, o_pixel_y, o_color}, 0);
    check("arst_meas", {o_line_clocks, o_hsync_width, o_frame_lines}, 0);
    check("arst_stat", {o_locked, o_frame_start, o_error, o_frame_sum}, 0);
    clear_pipe();
    n_fs = 0;
    gen_line(4, HS + HB + 4, HS + HB + 6, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    gen_line(4, HS + HB + 6, P, 1'b1, 1'b0, 1'b0);
    for (int l = 5; l < NL; l++) gen_line(l, 0, P, 1'b1, 1'b0, 1'b0);
    check("arst_no_fs", n_fs, 0);
    for (int f = 1; f <= 4; f++) begin
      gen_frame(0, NL, -1, 0, f > 1, 1'b0);
      if (f == 3) check("arst_lock_f3", o_locked, 0);
    end
    check("arst_lock_f4", o_locked, 1);
    check("arst_lines", o_frame_lines, NL);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
